// File: rtl/ofs_fim_pcie_ss_sb_tx_arb.sv
// Packet-atomic round-robin arbiter merging NUM_PORTS side-band-header AXI-S TX
// streams into one. A port is chosen in a single idle cycle, then owns the output
// until its tlast beat is accepted.
// Optional per-port packet counters are enabled by the OFS_PCIE_SS_TX_ARB_PKT_CNT_EN macro.
module ofs_fim_pcie_ss_sb_tx_arb #(
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned HDR_WIDTH  = 256,
  localparam int unsigned GW = $clog2(NUM_PORTS),
  localparam int unsigned KW = DATA_WIDTH / 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS-1:0]            in_tvalid,
  output logic [NUM_PORTS-1:0]            in_tready,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] in_tdata,
  input  logic [NUM_PORTS*KW-1:0]         in_tkeep,
  input  logic [NUM_PORTS-1:0]            in_tlast,
  input  logic [NUM_PORTS-1:0]            in_tuser_vendor,
  input  logic [NUM_PORTS-1:0]            in_tuser_hvalid,
  input  logic [NUM_PORTS*HDR_WIDTH-1:0]  in_tuser_hdr,
  output logic                            out_tvalid,
  input  logic                            out_tready,
  output logic [DATA_WIDTH-1:0]           out_tdata,
  output logic [KW-1:0]                   out_tkeep,
  output logic                            out_tlast,
  output logic                            out_tuser_vendor,
  output logic                            out_tuser_hvalid,
  output logic [HDR_WIDTH-1:0]            out_tuser_hdr,
  output logic [GW-1:0]                   out_grant,
`ifdef OFS_PCIE_SS_TX_ARB_PKT_CNT_EN
  output logic [NUM_PORTS*32-1:0]         pkt_cnt,
`endif
  output logic                            err_no_hdr
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e          state_q, state_d;
  logic [GW-1:0]   grant_q, grant_d, pick;
  logic            load_en, accept;
  logic            sop_q, sop_d, err_q, err_d, vld_q, vld_d;

  logic [DATA_WIDTH-1:0] data_a [NUM_PORTS];
  logic [KW-1:0]         keep_a [NUM_PORTS];
  logic [HDR_WIDTH-1:0]  hdr_a  [NUM_PORTS];

  logic [DATA_WIDTH-1:0] data_q;
  logic [KW-1:0]         keep_q;
  logic                  last_q, vendor_q, hvalid_q;
  logic [HDR_WIDTH-1:0]  hdr_q;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_unpack
    assign data_a[i] = in_tdata[i*DATA_WIDTH +: DATA_WIDTH];
    assign keep_a[i] = in_tkeep[i*KW +: KW];
    assign hdr_a[i]  = in_tuser_hdr[i*HDR_WIDTH +: HDR_WIDTH];
  end

  // Output register can take a beat when empty or draining this cycle
  assign load_en = out_tready | ~vld_q;
  assign accept  = (state_q == StBusy) & in_tvalid[grant_q] & load_en;

  // Round-robin pick: first valid port after the last grant, modulo NUM_PORTS
  always_comb begin
    logic        found;
    int unsigned idx;
    logic [GW-1:0] cand;
    found = 1'b0;
    idx   = 0;
    cand  = '0;
    pick  = grant_q;
    for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
      idx  = (32'(grant_q) + k) % NUM_PORTS;
      cand = GW'(idx);
      if (!found && in_tvalid[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      grant_q <= GW'(NUM_PORTS - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end

  // FSM next state: grant only moves in idle
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    unique case (state_q)
      StIdle: begin
        if (|in_tvalid) begin
          state_d = StBusy;
          grant_d = pick;
        end
      end
      StBusy: begin
        if (accept && in_tlast[grant_q]) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs: only the owning port sees ready
  always_comb begin
    in_tready = '0;
    if (state_q == StBusy) in_tready[grant_q] = load_en;
  end

  // Next-state for output valid, SOP flag and sticky header error
  always_comb begin
    vld_d = vld_q;
    sop_d = sop_q;
    err_d = err_q;
    if (load_en) vld_d = accept;
    if (state_q == StIdle && |in_tvalid) sop_d = 1'b1;
    else if (accept) sop_d = 1'b0;
    if (accept && sop_q && !in_tuser_hvalid[grant_q]) err_d = 1'b1;
  end

  // Output register and flags
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q    <= 1'b0;
      sop_q    <= 1'b0;
      err_q    <= 1'b0;
      data_q   <= '0;
      keep_q   <= '0;
      last_q   <= 1'b0;
      vendor_q <= 1'b0;
      hvalid_q <= 1'b0;
      hdr_q    <= '0;
    end else begin
      vld_q <= vld_d;
      sop_q <= sop_d;
      err_q <= err_d;
      if (accept) begin
        data_q   <= data_a[grant_q];
        keep_q   <= keep_a[grant_q];
        last_q   <= in_tlast[grant_q];
        vendor_q <= in_tuser_vendor[grant_q];
        hvalid_q <= in_tuser_hvalid[grant_q];
        hdr_q    <= hdr_a[grant_q];
      end
    end
  end

  assign out_tvalid       = vld_q;
  assign out_tdata        = data_q;
  assign out_tkeep        = keep_q;
  assign out_tlast        = last_q;
  assign out_tuser_vendor = vendor_q;
  assign out_tuser_hvalid = hvalid_q;
  assign out_tuser_hdr    = hdr_q;
  assign out_grant        = grant_q;
  assign err_no_hdr       = err_q;

`ifdef OFS_PCIE_SS_TX_ARB_PKT_CNT_EN
  logic [31:0] cnt_q [NUM_PORTS];

  // Per-port packet counters, bumped on each accepted tlast beat; wrap naturally
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_PORTS; i++) cnt_q[i] <= '0;
    end else if (accept && in_tlast[grant_q]) begin
      cnt_q[grant_q] <= cnt_q[grant_q] + 32'd1;
    end
  end

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_cnt
    assign pkt_cnt[i*32 +: 32] = cnt_q[i];
  end
`endif

endmodule

// File: tb/tb_ofs_fim_pcie_ss_sb_tx_arb.sv
// Scoreboard bench for the side-band TX arbiter: stimulus pushes expected beats,
// a separate monitor pops and compares on every output handshake.
module tb_ofs_fim_pcie_ss_sb_tx_arb;
  localparam int NP = 4;
  localparam int DW = 512;
  localparam int HW = 256;
  localparam int KW = DW / 8;
  localparam int GW = 2;
`ifdef OFS_PCIE_SS_TX_ARB_PKT_CNT_EN
  localparam int NRAND = 10000;
`else
  localparam int NRAND = 300;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NP-1:0]    in_tvalid, in_tready, in_tlast, in_tuser_vendor, in_tuser_hvalid;
  logic [NP*DW-1:0] in_tdata;
  logic [NP*KW-1:0] in_tkeep;
  logic [NP*HW-1:0] in_tuser_hdr;
  logic             out_tvalid, out_tready, out_tlast, out_tuser_vendor, out_tuser_hvalid;
  logic [DW-1:0]    out_tdata;
  logic [KW-1:0]    out_tkeep;
  logic [HW-1:0]    out_tuser_hdr;
  logic [GW-1:0]    out_grant;
  logic             err_no_hdr;
`ifdef OFS_PCIE_SS_TX_ARB_PKT_CNT_EN
  logic [NP*32-1:0] pkt_cnt;
`endif

  ofs_fim_pcie_ss_sb_tx_arb #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .HDR_WIDTH(HW)) dut (
    .clk              (clk),
    .rst              (rst),
    .in_tvalid        (in_tvalid),
    .in_tready        (in_tready),
    .in_tdata         (in_tdata),
    .in_tkeep         (in_tkeep),
    .in_tlast         (in_tlast),
    .in_tuser_vendor  (in_tuser_vendor),
    .in_tuser_hvalid  (in_tuser_hvalid),
    .in_tuser_hdr     (in_tuser_hdr),
    .out_tvalid       (out_tvalid),
    .out_tready       (out_tready),
    .out_tdata        (out_tdata),
    .out_tkeep        (out_tkeep),
    .out_tlast        (out_tlast),
    .out_tuser_vendor (out_tuser_vendor),
    .out_tuser_hvalid (out_tuser_hvalid),
    .out_tuser_hdr    (out_tuser_hdr),
    .out_grant        (out_grant),
`ifdef OFS_PCIE_SS_TX_ARB_PKT_CNT_EN
    .pkt_cnt          (pkt_cnt),
`endif
    .err_no_hdr       (err_no_hdr)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic          vendor;
    logic          hvalid;
    logic [HW-1:0] hdr;
  } beat_t;

  beat_t pq[NP][$];      // per-port stimulus
  beat_t exp_q[$];       // global expected order (directed tests)
  beat_t exp_pq[NP][$];  // per-port expected order (random test)

  int errors = 0;
  int checks = 0;
  bit rand_mode = 1'b0;
  bit rdy = 1'b1;
  bit rdy_rand = 1'b0;
  int cnt[NP];

  // Tag layout: port[31:28], packet[27:8], beat[7:0]
  function automatic beat_t mk(int p, int pkt, int b, bit last, bit hv);
    beat_t       r;
    logic [31:0] tag;
    tag      = {p[3:0], pkt[19:0], b[7:0]};
    r.data   = {16{tag}};
    r.keep   = {2{tag}};
    r.last   = last;
    r.vendor = tag[0] ^ tag[8];
    r.hvalid = hv;
    r.hdr    = hv ? {8{~tag}} : {8{tag ^ 32'h5A5A_5A5A}};
    return r;
  endfunction

  function automatic bit beat_eq(beat_t a, beat_t b);
    return a.data === b.data && a.keep === b.keep && a.last === b.last &&
           a.vendor === b.vendor && a.hvalid === b.hvalid && a.hdr === b.hdr;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic push_pkt(int p, int pkt, int len, bit bad, bit global);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b = mk(p, pkt, i, i == len - 1, (i == 0) && !bad);
      pq[p].push_back(b);
      if (global) exp_q.push_back(b);
      else exp_pq[p].push_back(b);
    end
  endtask

  // One cycle: drive at negedge, then retire beats that will handshake at the next posedge
  task automatic step();
    beat_t b;
    @(negedge clk);
    out_tready = rdy_rand ? ($urandom_range(15) != 0) : rdy;
    for (int p = 0; p < NP; p++) begin
      if (pq[p].size() > 0) begin
        b                        = pq[p][0];
        in_tvalid[p]             = 1'b1;
        in_tdata[p*DW +: DW]     = b.data;
        in_tkeep[p*KW +: KW]     = b.keep;
        in_tlast[p]              = b.last;
        in_tuser_vendor[p]       = b.vendor;
        in_tuser_hvalid[p]       = b.hvalid;
        in_tuser_hdr[p*HW +: HW] = b.hdr;
      end else begin
        in_tvalid[p] = 1'b0;
      end
    end
    #1;
    if (!rst) begin
      for (int p = 0; p < NP; p++)
        if (in_tvalid[p] && in_tready[p]) void'(pq[p].pop_front());
    end
  endtask

  task automatic flush();
    for (int p = 0; p < NP; p++) begin
      pq[p].delete();
      exp_pq[p].delete();
    end
    exp_q.delete();
  endtask

  task automatic do_reset();
    rdy = 1'b0;
    rst = 1'b1;
    flush();
    step();
    step();
    rst = 1'b0;
    rdy = 1'b1;
  endtask

  // Monitor: scoreboard compare plus stall/ready invariants
  beat_t cur, prev, e;
  bit    prev_stall = 1'b0;
  bit    mid_pkt = 1'b0;
  int    mp, cur_port;
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        prev_stall = 1'b0;
        mid_pkt    = 1'b0;
      end else begin
        cur = '{out_tdata, out_tkeep, out_tlast, out_tuser_vendor, out_tuser_hvalid,
                out_tuser_hdr};
        if (prev_stall) begin
          checks++;
          if (!out_tvalid || !beat_eq(cur, prev)) begin
            errors++;
            $display("FAIL stall_hold: got vld=%b tag=%h held tag=%h", out_tvalid,
                     cur.data[31:0], prev.data[31:0]);
          end
        end
        if (out_tvalid && !out_tready) chk("stall_in_tready", 64'(in_tready), 64'd0);
        if (in_tready != '0) chk("ready_on_grant", 64'(in_tready), 64'(4'b1 << out_grant));
        if (out_tvalid && out_tready) begin
          mp = int'(cur.data[31:28]);
          checks++;
          if (rand_mode && mid_pkt && mp != cur_port) begin
            errors++;
            $display("FAIL interleave: got port %0d expected port %0d", mp, cur_port);
          end else if ((rand_mode && (mp >= NP || exp_pq[mp % NP].size() == 0)) ||
                       (!rand_mode && exp_q.size() == 0)) begin
            errors++;
            $display("FAIL unexpected_beat: got tag=%h expected none", cur.data[31:0]);
          end else begin
            e = rand_mode ? exp_pq[mp].pop_front() : exp_q.pop_front();
            if (!beat_eq(cur, e)) begin
              errors++;
              $display("FAIL beat: got tag=%h last=%b hv=%b hdr=%h expected tag=%h last=%b hv=%b hdr=%h",
                       cur.data[31:0], cur.last, cur.hvalid, cur.hdr[31:0],
                       e.data[31:0], e.last, e.hvalid, e.hdr[31:0]);
            end
          end
          cur_port = mp;
          mid_pkt  = !cur.last;
        end
        prev_stall = out_tvalid && !out_tready;
        prev       = cur;
      end
    end
  end

  initial begin
    int tot, rem;
    rst = 1'b1;
    in_tvalid = '0; in_tdata = '0; in_tkeep = '0; in_tlast = '0;
    in_tuser_vendor = '0; in_tuser_hvalid = '0; in_tuser_hdr = '0;
    out_tready = 1'b0;
    do_reset();
    chk("rst_out_tvalid", 64'(out_tvalid), 64'd0);
    chk("rst_in_tready", 64'(in_tready), 64'd0);
    chk("rst_grant", 64'(out_grant), 64'd3);
    chk("rst_err", 64'(err_no_hdr), 64'd0);

    // Single 3-beat packet from port 0: first output two cycles after valid
    push_pkt(0, 0, 3, 1'b0, 1'b1);
    step();
    chk("lat_cycle_n", 64'(out_tvalid), 64'd0);
    step();
    chk("lat_cycle_n1", 64'(out_tvalid), 64'd0);
    chk("lat_grant", 64'(out_grant), 64'd0);
    step();
    chk("lat_cycle_n2", 64'(out_tvalid), 64'd1);
    repeat (4) step();
    #2;
    chk("single_drained", 64'(exp_q.size()), 64'd0);

    // All ports busy, 2-beat packets: order 0,1,2,3,0,1 with one idle cycle each
    do_reset();
    push_pkt(0, 1, 2, 1'b0, 1'b1);
    push_pkt(1, 2, 2, 1'b0, 1'b1);
    push_pkt(2, 3, 2, 1'b0, 1'b1);
    push_pkt(3, 4, 2, 1'b0, 1'b1);
    push_pkt(0, 5, 2, 1'b0, 1'b1);
    push_pkt(1, 6, 2, 1'b0, 1'b1);
    repeat (18) step();
    #2;
    chk("rr_gap_pending", 64'(exp_q.size()), 64'd1);
    step();
    #2;
    chk("rr_gap_done", 64'(exp_q.size()), 64'd0);

    // Backpressure pattern 1,0,0,1 on a 4-beat packet from port 1
    do_reset();
    push_pkt(1, 7, 4, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      rdy = (i % 4 == 0) || (i % 4 == 3);
      step();
    end
    rdy = 1'b1;
    repeat (3) step();
    #2;
    chk("stall_drained", 64'(exp_q.size()), 64'd0);

    // Missing header on SOP of port 2: sticky error, beat still forwarded
    do_reset();
    chk("err_clean", 64'(err_no_hdr), 64'd0);
    push_pkt(2, 8, 2, 1'b1, 1'b1);
    for (int i = 0; i < 10 && pq[2].size() == 2; i++) step();
    chk("err_before_accept", 64'(err_no_hdr), 64'd0);
    step();
    chk("err_after_accept", 64'(err_no_hdr), 64'd1);
    repeat (4) step();
    push_pkt(0, 9, 2, 1'b0, 1'b1);
    repeat (6) step();
    #2;
    chk("err_sticky", 64'(err_no_hdr), 64'd1);
    chk("err_drained", 64'(exp_q.size()), 64'd0);
    do_reset();
    chk("err_cleared", 64'(err_no_hdr), 64'd0);

    // Reset mid-packet, then port 0 wins over port 3
    push_pkt(3, 10, 5, 1'b0, 1'b1);
    for (int i = 0; i < 12 && pq[3].size() > 3; i++) step();
    rdy = 1'b0;
    rst = 1'b1;
    flush();
    step();
    rst = 1'b0;
    rdy = 1'b1;
    step();
    chk("midrst_out_tvalid", 64'(out_tvalid), 64'd0);
    chk("midrst_in_tready", 64'(in_tready), 64'd0);
    chk("midrst_grant", 64'(out_grant), 64'd3);
    push_pkt(0, 11, 1, 1'b0, 1'b1);
    push_pkt(3, 12, 1, 1'b0, 1'b1);
    step();
    step();
    chk("midrst_prio", 64'(out_grant), 64'd0);
    repeat (6) step();
    #2;
    chk("midrst_drained", 64'(exp_q.size()), 64'd0);

    // Random packets with random backpressure, per-port ordering
    do_reset();
    for (int p = 0; p < NP; p++) cnt[p] = 0;
    for (int n = 0; n < NRAND; n++) begin
      int p;
      p = int'($urandom_range(NP - 1));
      push_pkt(p, n, int'($urandom_range(3, 1)), 1'b0, 1'b0);
      cnt[p]++;
    end
    rand_mode = 1'b1;
    rdy_rand  = 1'b1;
    rem = NRAND;
    for (int c = 0; c < 80000 && rem > 0; c++) begin
      step();
      #2;
      rem = 0;
      for (int p = 0; p < NP; p++) rem += exp_pq[p].size();
    end
    chk("rand_drained", 64'(rem), 64'd0);
    chk("rand_err", 64'(err_no_hdr), 64'd0);
`ifdef OFS_PCIE_SS_TX_ARB_PKT_CNT_EN
    tot = 0;
    for (int p = 0; p < NP; p++) begin
      chk("pkt_cnt_port", 64'(pkt_cnt[p*32 +: 32]), 64'(cnt[p]));
      tot += int'(pkt_cnt[p*32 +: 32]);
    end
    chk("pkt_cnt_sum", 64'(tot), 64'(NRAND));
`else
    tot = 0;
`endif
    rdy_rand = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
